// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU control sequencer: state encoding,
// instruction field layout, opcode/ALU/vsel codes and the per-state control map.
package alu_sequencer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_IMM_W = 8;
  localparam int IR_W      = 16;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_WR_IMM = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Major opcodes
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Minor op field values
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Writeback source select
  localparam logic VSEL_C   = 1'b0;
  localparam logic VSEL_IMM = 1'b1;

  // Instruction word layout, msb first; packs to exactly IR_W bits
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } fields_t;

  // Control outputs presented while the FSM sits in a given state
  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       vsel;
    logic [1:0] alu_op;
    logic       done;
    logic       err;
    logic       ready;
  } ctrl_t;

  // Control word for state s while holding instruction f
  function automatic ctrl_t ctrl_for(input state_t s, input fields_t f);
    ctrl_t c;
    c = '0;
    case (s)
      S_WAIT: c.ready = 1'b1;
      S_WR_IMM: begin
        c.write    = 1'b1;
        c.writenum = f.rn;
        c.vsel     = VSEL_IMM;
        c.done     = 1'b1;
      end
      S_GET_A: begin
        c.readnum = f.rn;
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = f.rm;
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.loadc = 1'b1;
        if (f.opcode == OPC_MOV) begin
          // register move is computed as 0 + shifted Rm
          c.asel   = 1'b1;
          c.alu_op = ALU_ADD;
        end else begin
          c.alu_op = f.op;
        end
        if (f.opcode == OPC_ALU && f.op == OP_CMP) begin
          c.loads = 1'b1;
          c.done  = 1'b1;
        end
      end
      S_WB: begin
        c.writenum = f.rd;
        c.vsel     = VSEL_C;
        c.write    = 1'b1;
        c.done     = 1'b1;
      end
      S_ERR: c.err = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational instruction decode: field slices, sign-extended immediate,
// legality and the state to enter when the instruction is accepted from WAIT.
module seq_decode
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMM_W = DEF_IMM_W
) (
  input  logic [IR_W-1:0]  ir,
  output fields_t          fields,
  output state_t           target,
  output logic             legal,
  output logic             is_cmp,
  output logic [WIDTH-1:0] sximm8
);

  assign fields = fields_t'(ir);
  assign sximm8 = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign is_cmp = (fields.opcode == OPC_ALU) && (fields.op == OP_CMP);

  // Map opcode/op to the first execution state; everything unlisted is illegal
  always_comb begin
    target = S_ERR;
    legal  = 1'b0;
    case (fields.opcode)
      OPC_MOV: begin
        if (fields.op == OP_MOV_IMM) begin
          target = S_WR_IMM;
          legal  = 1'b1;
        end else if (fields.op == OP_MOV_REG) begin
          target = S_GET_B;
          legal  = 1'b1;
        end
      end
      OPC_ALU: begin
        legal  = 1'b1;
        target = (fields.op == OP_MVN) ? S_GET_B : S_GET_A;
      end
      default: begin
        target = S_ERR;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Moore sequencer for the ALU datapath: accepts one instruction per handshake,
// steps through operand reads, execute and writeback, and latches ZVN on CMP.
// All control outputs are registered from the next state and next ir.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMM_W = DEF_IMM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IR_W-1:0]  instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       zvn,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             vsel,
  output logic [1:0]       alu_op,
  output logic [1:0]       shift,
  output logic [WIDTH-1:0] sximm8,
  output logic [2:0]       status,
  output logic             done,
  output logic             err
);

  state_t           state_reg;
  state_t           state_next;
  logic [IR_W-1:0]  ir_reg;
  logic [IR_W-1:0]  ir_next;
  ctrl_t            ctrl_reg;
  ctrl_t            ctrl_next;
  logic             accept;

  fields_t          dec_fields;
  state_t           dec_target;
  logic             dec_legal;
  logic             dec_is_cmp;
  logic [WIDTH-1:0] dec_sximm8;

  assign accept  = instr_valid & ctrl_reg.ready;
  assign ir_next = accept ? instr : ir_reg;

  // Decode the instruction that will be held next cycle, so registered
  // outputs already reflect a freshly accepted word.
  seq_decode #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W)
  ) u_decode (
    .ir     (ir_next),
    .fields (dec_fields),
    .target (dec_target),
    .legal  (dec_legal),
    .is_cmp (dec_is_cmp),
    .sximm8 (dec_sximm8)
  );

  // Next-state selection
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT:   if (accept) state_next = dec_legal ? dec_target : S_ERR;
      S_WR_IMM: state_next = S_WAIT;
      S_GET_A:  state_next = S_GET_B;
      S_GET_B:  state_next = S_EXEC;
      S_EXEC:   state_next = dec_is_cmp ? S_WAIT : S_WB;
      S_WB:     state_next = S_WAIT;
      S_ERR:    state_next = S_WAIT;
      default:  state_next = S_WAIT;
    endcase
  end

  assign ctrl_next = ctrl_for(state_next, dec_fields);

  // State, instruction, status and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_WAIT;
      ir_reg    <= '0;
      ctrl_reg  <= '0;   // ready rises on the first edge with reset low
      status    <= '0;
      shift     <= '0;
      sximm8    <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
      ctrl_reg  <= ctrl_next;
      shift     <= dec_fields.sh;
      sximm8    <= dec_sximm8;
      // loads is only ever high during EXEC of CMP
      if (ctrl_reg.loads) status <= zvn;
    end
  end

  assign instr_ready = ctrl_reg.ready;
  assign readnum     = ctrl_reg.readnum;
  assign writenum    = ctrl_reg.writenum;
  assign write       = ctrl_reg.write;
  assign loada       = ctrl_reg.loada;
  assign loadb       = ctrl_reg.loadb;
  assign loadc       = ctrl_reg.loadc;
  assign loads       = ctrl_reg.loads;
  assign asel        = ctrl_reg.asel;
  assign vsel        = ctrl_reg.vsel;
  assign alu_op      = ctrl_reg.alu_op;
  assign done        = ctrl_reg.done;
  assign err         = ctrl_reg.err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: per-cycle expected control records are
// queued when an instruction is driven and popped as the DUT steps through it.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  zvn;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, vsel, done, err;
  logic [1:0]  alu_op, shift;
  logic [15:0] sximm8;
  logic [2:0]  status;

  int passed = 0;
  int total  = 0;
  logic [2:0] exp_status;

  alu_sequencer #(.WIDTH(16), .IMM_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .zvn         (zvn),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .vsel        (vsel),
    .alu_op      (alu_op),
    .shift       (shift),
    .sximm8      (sximm8),
    .status      (status),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // strobe vector order {write,loada,loadb,loadc,loads,done,err}
  localparam logic [6:0] S_WR = 7'b1000000;
  localparam logic [6:0] S_LA = 7'b0100000;
  localparam logic [6:0] S_LB = 7'b0010000;
  localparam logic [6:0] S_LC = 7'b0001000;
  localparam logic [6:0] S_LS = 7'b0000100;
  localparam logic [6:0] S_DN = 7'b0000010;
  localparam logic [6:0] S_ER = 7'b0000001;

  typedef struct packed {
    logic       ready;
    logic [6:0] strobes;
    logic       rd_care;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       exec;
    logic [1:0] alu_op;
    logic       asel;
    logic       vsel;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic rdy, input logic [6:0] s, input logic rc,
                              input logic [2:0] rn, input logic [2:0] wn, input logic ex,
                              input logic [1:0] op, input logic as, input logic vs);
    exp_t e;
    e.ready = rdy; e.strobes = s; e.rd_care = rc; e.readnum = rn; e.writenum = wn;
    e.exec = ex; e.alu_op = op; e.asel = as; e.vsel = vs;
    return e;
  endfunction

  function automatic logic [6:0] strobes_now();
    return {write, loada, loadb, loadc, loads, done, err};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle behaviour of one instruction, from its opcode table
  task automatic push_expected(input logic [15:0] w, input logic [2:0] z);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    opc = w[15:13]; op = w[12:11]; rn = w[10:8]; rd = w[7:5]; rm = w[2:0];
    if (opc == 3'b110 && op == 2'b10) begin
      sb.push_back(mk(0, S_WR | S_DN, 0, 3'd0, rn, 0, 2'b00, 0, 1));
    end else if (opc == 3'b110 && op == 2'b00) begin
      sb.push_back(mk(0, S_LB, 1, rm, 3'd0, 0, 2'b00, 0, 0));
      sb.push_back(mk(0, S_LC, 0, 3'd0, 3'd0, 1, 2'b00, 1, 0));
      sb.push_back(mk(0, S_WR | S_DN, 0, 3'd0, rd, 0, 2'b00, 0, 0));
    end else if (opc == 3'b101 && op != 2'b11) begin
      sb.push_back(mk(0, S_LA, 1, rn, 3'd0, 0, 2'b00, 0, 0));
      sb.push_back(mk(0, S_LB, 1, rm, 3'd0, 0, 2'b00, 0, 0));
      if (op == 2'b01) begin
        sb.push_back(mk(0, S_LC | S_LS | S_DN, 0, 3'd0, 3'd0, 1, 2'b01, 0, 0));
        exp_status = z;
      end else begin
        sb.push_back(mk(0, S_LC, 0, 3'd0, 3'd0, 1, op, 0, 0));
        sb.push_back(mk(0, S_WR | S_DN, 0, 3'd0, rd, 0, 2'b00, 0, 0));
      end
    end else if (opc == 3'b101) begin
      sb.push_back(mk(0, S_LB, 1, rm, 3'd0, 0, 2'b00, 0, 0));
      sb.push_back(mk(0, S_LC, 0, 3'd0, 3'd0, 1, 2'b11, 0, 0));
      sb.push_back(mk(0, S_WR | S_DN, 0, 3'd0, rd, 0, 2'b00, 0, 0));
    end else begin
      sb.push_back(mk(0, S_ER, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0));
    end
    sb.push_back(mk(1, 7'b0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0));
  endtask

  // Drive one instruction from WAIT and score every cycle until WAIT again
  task automatic issue(input logic [15:0] w, input logic [2:0] z);
    exp_t e;
    logic [15:0] exp_sx;
    int cycles;
    exp_sx = {{8{w[7]}}, w[7:0]};
    check("ready_before", {31'd0, instr_ready}, 32'd1);
    instr = w; instr_valid = 1'b1; zvn = z;
    push_expected(w, z);
    step();
    instr_valid = 1'b0;
    instr = 16'h0000;
    cycles = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cycles++;
      check("ready", {31'd0, instr_ready}, {31'd0, e.ready});
      check("strobes", {25'd0, strobes_now()}, {25'd0, e.strobes});
      check("shift", {30'd0, shift}, {30'd0, w[4:3]});
      check("sximm8", {16'd0, sximm8}, {16'd0, exp_sx});
      if (e.rd_care) check("readnum", {29'd0, readnum}, {29'd0, e.readnum});
      if (e.strobes[6]) begin
        check("writenum", {29'd0, writenum}, {29'd0, e.writenum});
        check("vsel", {31'd0, vsel}, {31'd0, e.vsel});
      end
      if (e.exec) begin
        check("alu_op", {30'd0, alu_op}, {30'd0, e.alu_op});
        check("asel", {31'd0, asel}, {31'd0, e.asel});
      end
      if (sb.size() > 0) step();
    end
    check("status", {29'd0, status}, {29'd0, exp_status});
    $display("instr %04h zvn %03b: %0d cycles scored, status %03b", w, z, cycles, status);
  endtask

  initial begin
    reset = 1'b1; instr = 16'h0; instr_valid = 1'b0; zvn = 3'b000;
    exp_status = 3'b000;
    step(); step();
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_strobes", {25'd0, strobes_now()}, 32'd0);
    check("rst_status", {29'd0, status}, 32'd0);
    check("rst_sximm8", {16'd0, sximm8}, 32'd0);
    reset = 1'b0;
    step();
    check("ready_after_rst", {31'd0, instr_ready}, 32'd1);

    issue(16'hD3FB, 3'b000);   // MOV R3,#-5
    issue(16'hA140, 3'b010);   // ADD R2,R1,R0
    issue(16'hA900, 3'b100);   // CMP R1,R0
    issue(16'hB88D, 3'b001);   // MVN R4,R5,sh=01
    issue(16'hE000, 3'b111);   // illegal opcode 111
    issue(16'hC800, 3'b011);   // illegal MOV op 01
    issue(16'hC032, 3'b110);   // MOV R1,R2,sh=10
    issue(16'hB6FD, 3'b101);   // AND R7,R6,R5,sh=11
    issue(16'hD77F, 3'b000);   // MOV R7,#127

    // Reset in EXEC of ADD with instr_valid held high
    instr = 16'hA140; instr_valid = 1'b1; zvn = 3'b001;
    step();                     // GET_A
    step();                     // GET_B
    step();                     // EXEC
    check("pre_rst_loadc", {31'd0, loadc}, 32'd1);
    reset = 1'b1;
    step();
    check("midrst_write", {31'd0, write}, 32'd0);
    check("midrst_strobes", {25'd0, strobes_now()}, 32'd0);
    check("midrst_status", {29'd0, status}, 32'd0);
    check("midrst_ready", {31'd0, instr_ready}, 32'd0);
    exp_status = 3'b000;
    reset = 1'b0;
    step();
    check("postrst_ready", {31'd0, instr_ready}, 32'd1);
    check("postrst_strobes", {25'd0, strobes_now()}, 32'd0);
    instr_valid = 1'b0;
    $display("reset during EXEC: flight discarded, status %03b", status);

    issue(16'hA140, 3'b111);   // ADD again after reset
    issue(16'hD3FB, 3'b000);   // back-to-back MOV imm
    issue(16'hA900, 3'b011);   // CMP latches new flags

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
